alu_issue_unit: RTL and testbench
=================================

// Module: alu_issue_unit
// PURPOSE
//  Initiator side of the ALU command interface: accepts 32-bit ALU instruction words via valid/ready,
//  reads operands from a local 16-entry register file and drives command/a/b to an external ALU.
//  It then samples the ALU's out/zero, writes the result back and returns a response via valid/ready.
//  Sits between fetch/test harness and the combinational ALU; one instruction in flight.
// PARAMETERS
//  XLEN   32  data width of operands, results, register file entries
// PORTS
//  clock           in   1     system clock
//  reset           in   1     synchronous, active-low reset
//  io_req_valid    in   1     instruction word valid
//  io_req_ready    out  1     unit can accept instruction (IDLE only)
//  io_req_bits     in   32    [31:24] cmd, [23:20] rd, [19:16] rs1, [15:12] rs2, [11] use_imm, [10:0] imm
//  io_alu_command  out  8     command to ALU (0 = no-op outside EXEC)
//  io_alu_a        out  XLEN  operand A to ALU
//  io_alu_b        out  XLEN  operand B to ALU
//  io_alu_out      in   XLEN  ALU result (combinational from command/a/b)
//  io_alu_zero     in   1     ALU result == 0
//  io_resp_valid   out  1     response valid
//  io_resp_ready   in   1     consumer accepts response
//  io_resp_data    out  XLEN  result written to rd
//  io_resp_zero    out  1     captured io_alu_zero
//  io_resp_err     out  1     cmd was illegal; nothing executed or written
//  io_busy         out  1     state != IDLE
//  io_dbg_addr     in   4     debug register read address
//  io_dbg_data     out  XLEN  combinational read of reg[io_dbg_addr]; reg 0 reads 0
// BEHAVIOUR
//  - Reset (reset==0 at clock edge): state=IDLE, all 16 regs=0, io_alu_*=0, io_resp_*=0, io_busy=0.
//    io_req_ready=0 while reset is held; 1 in the first cycle after release. Reset aborts any operation.
//  - FSM: IDLE -> READ -> EXEC -> RESP -> IDLE. Accept at cycle T when io_req_valid && io_req_ready.
//  - IDLE: io_req_ready=1. On accept, latch io_req_bits and go to READ.
//  - READ (T+1): a = reg[rs1].
//    b = use_imm ? sign-extend(imm[10:0]) to XLEN : reg[rs2]. reg 0 always reads 0. Check cmd.
//    cmd in 1..8 (ADD,SUB,AND,OR,XOR,SRL,SRA,SLL) -> EXEC; otherwise set err=1 and go straight to RESP.
//  - EXEC (T+2): registered io_alu_command=cmd, io_alu_a=a, io_alu_b=b, valid exactly this cycle.
//    Full b is passed; ALU uses b[4:0] for shifts. At end of cycle capture io_alu_out/io_alu_zero
//    into io_resp_data/io_resp_zero and write reg[rd] (write ignored when rd==0) -> RESP.
//  - Outside EXEC: io_alu_command=0, io_alu_a=0, io_alu_b=0.
//  - RESP (T+3 earliest): io_resp_valid=1; data/zero/err stable until io_resp_valid && io_resp_ready.
//    On handshake -> IDLE; resp_* cleared; next accept no earlier than following cycle. Max 1 op / 4 cycles.
//  - Error path: io_resp_err=1, io_resp_data=0, io_resp_zero=0, no ALU command issued, no reg write.
//  - Arithmetic wrap is the ALU's (mod 2^XLEN); unit adds no overflow logic.
//  - Debug read shows post-writeback value from the cycle after EXEC.
// STRUCTURE
//  - Shared package alu_pkg: XLEN; CMD_NOP=0, CMD_ADD=1, SUB=2, AND=3, OR=4, XOR=5, SRL=6, SRA=7, SLL=8;
//    instruction field bit positions; FSM state enum {IDLE,READ,EXEC,RESP}.
//  - Sub-module alu_regfile: 16 x XLEN, 2 read + 1 debug read (comb), 1 write (sync), r0 hardwired 0,
//    synchronous active-low clear.
//  - Top: FSM, instruction latch, operand/imm mux, ALU drive regs, response regs.
//  - Bench instantiates the existing ALU beside this unit and connects the io_alu_* ports to it.
// TESTING
//  1. Reset then release: io_req_ready=1, io_resp_valid=0, io_alu_command=0, io_dbg_data=0 for addrs 0..15.
//  2. ADD r1=r0+imm 5 (0x0110_0805) at T: T+2 alu_command=1,a=0,b=5; T+3 resp_data=5,zero=0; dbg r1=5.
//  3. SUB r2=r1-r1 (0x0221_1000): resp_data=0, resp_zero=1, resp_err=0; dbg r2=0.
//  4. ADD r3=r0+imm 0x7FB -> 0xFFFFFFFB; SRA r4=r3>>imm 1 -> 0xFFFFFFFD; SRL r5=r3>>imm 1 -> 0x7FFFFFFD.
//  5. cmd 0x09 and cmd 0x00: resp_err=1, data=0, alu_command stays 0 all cycles; ADD rd=0 imm 7 -> dbg r0=0.
//  6. Hold resp_ready=0 for 5 cycles: resp_valid/data stable, req_ready=0, busy=1; reset low during EXEC ->
//     next cycle IDLE, all outputs 0, regs 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue unit: data width, command codes,
// instruction field positions and the sequencing state enum.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [7:0] CMD_NOP = 8'd0;
  localparam logic [7:0] CMD_ADD = 8'd1;
  localparam logic [7:0] CMD_SUB = 8'd2;
  localparam logic [7:0] CMD_AND = 8'd3;
  localparam logic [7:0] CMD_OR  = 8'd4;
  localparam logic [7:0] CMD_XOR = 8'd5;
  localparam logic [7:0] CMD_SRL = 8'd6;
  localparam logic [7:0] CMD_SRA = 8'd7;
  localparam logic [7:0] CMD_SLL = 8'd8;

  localparam int CMD_LSB     = 24;
  localparam int RD_LSB      = 20;
  localparam int RS1_LSB     = 16;
  localparam int RS2_LSB     = 12;
  localparam int USE_IMM_BIT = 11;
  localparam int IMM_W       = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_e;

  function automatic logic [XLEN-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

  function automatic logic cmd_legal(input logic [7:0] cmd);
    return (cmd >= CMD_ADD) && (cmd <= CMD_SLL);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// 16 x XLEN register file: two operand reads plus a debug read (all combinational),
// one synchronous write, r0 hardwired to zero, synchronous active-low clear.
module alu_regfile
  import alu_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic [3:0]      rs1_addr_i,
  input  logic [3:0]      rs2_addr_i,
  input  logic [3:0]      dbg_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic [XLEN-1:0] dbg_data_o,
  input  logic            we_i,
  input  logic [3:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i
);

  logic [XLEN-1:0] regs_q [16];

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != 4'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rs1_data_o = (rs1_addr_i == 4'd0) ? '0 : regs_q[rs1_addr_i];
  assign rs2_data_o = (rs2_addr_i == 4'd0) ? '0 : regs_q[rs2_addr_i];
  assign dbg_data_o = (dbg_addr_i == 4'd0) ? '0 : regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_unit.sv
// Issues one ALU instruction at a time: latch, read operands, drive the external
// ALU for one cycle, write back and hold the response until it is taken.
module alu_issue_unit
  import alu_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            io_req_valid,
  output logic            io_req_ready,
  input  logic [31:0]     io_req_bits,
  output logic [7:0]      io_alu_command,
  output logic [XLEN-1:0] io_alu_a,
  output logic [XLEN-1:0] io_alu_b,
  input  logic [XLEN-1:0] io_alu_out,
  input  logic            io_alu_zero,
  output logic            io_resp_valid,
  input  logic            io_resp_ready,
  output logic [XLEN-1:0] io_resp_data,
  output logic            io_resp_zero,
  output logic            io_resp_err,
  output logic            io_busy,
  input  logic [3:0]      io_dbg_addr,
  output logic [XLEN-1:0] io_dbg_data
);

  state_e          state_q, state_d;
  logic [31:0]     instr_q;
  logic [7:0]      cmd_q;
  logic [XLEN-1:0] a_q, b_q;
  logic            resp_valid_q, resp_zero_q, resp_err_q;
  logic [XLEN-1:0] resp_data_q;

  logic [7:0]      f_cmd;
  logic [3:0]      f_rd, f_rs1, f_rs2;
  logic            f_use_imm;
  logic [XLEN-1:0] rs1_data, rs2_data, op_b;
  logic            legal, accept, resp_fire, rf_we;

  assign f_cmd     = instr_q[CMD_LSB +: 8];
  assign f_rd      = instr_q[RD_LSB +: 4];
  assign f_rs1     = instr_q[RS1_LSB +: 4];
  assign f_rs2     = instr_q[RS2_LSB +: 4];
  assign f_use_imm = instr_q[USE_IMM_BIT];
  assign op_b      = f_use_imm ? sext_imm(instr_q[IMM_W-1:0]) : rs2_data;
  assign legal     = cmd_legal(f_cmd);
  assign accept    = io_req_valid && io_req_ready;
  assign resp_fire = resp_valid_q && io_resp_ready;

  alu_regfile u_regfile (
    .clock      (clock),
    .reset      (reset),
    .rs1_addr_i (f_rs1),
    .rs2_addr_i (f_rs2),
    .dbg_addr_i (io_dbg_addr),
    .rs1_data_o (rs1_data),
    .rs2_data_o (rs2_data),
    .dbg_data_o (io_dbg_data),
    .we_i       (rf_we),
    .waddr_i    (f_rd),
    .wdata_i    (io_alu_out)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      instr_q      <= '0;
      cmd_q        <= CMD_NOP;
      a_q          <= '0;
      b_q          <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_zero_q  <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) instr_q <= io_req_bits;
      // ALU drive regs are loaded only on the READ->EXEC edge, so they are zero everywhere else
      cmd_q <= CMD_NOP;
      a_q   <= '0;
      b_q   <= '0;
      if (state_q == READ && legal) begin
        cmd_q <= f_cmd;
        a_q   <= rs1_data;
        b_q   <= op_b;
      end
      if (state_q == EXEC) begin
        resp_valid_q <= 1'b1;
        resp_data_q  <= io_alu_out;
        resp_zero_q  <= io_alu_zero;
        resp_err_q   <= 1'b0;
      end else if (state_q == READ && !legal) begin
        resp_valid_q <= 1'b1;
        resp_data_q  <= '0;
        resp_zero_q  <= 1'b0;
        resp_err_q   <= 1'b1;
      end else if (resp_fire) begin
        resp_valid_q <= 1'b0;
        resp_data_q  <= '0;
        resp_zero_q  <= 1'b0;
        resp_err_q   <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = READ;
      READ:    state_d = legal ? EXEC : RESP;
      EXEC:    state_d = RESP;
      RESP:    if (resp_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready is also gated by reset so nothing is accepted while reset is still held.
  always_comb begin
    io_req_ready = (state_q == IDLE) && reset;
    io_busy      = (state_q != IDLE);
    rf_we        = (state_q == EXEC);
  end

  assign io_alu_command = cmd_q;
  assign io_alu_a       = a_q;
  assign io_alu_b       = b_q;
  assign io_resp_valid  = resp_valid_q;
  assign io_resp_data   = resp_data_q;
  assign io_resp_zero   = resp_zero_q;
  assign io_resp_err    = resp_err_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioural ALU wired to its io_alu_* ports.
module tb_alu_issue_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_req_valid = 1'b0;
  logic        io_req_ready;
  logic [31:0] io_req_bits = '0;
  logic [7:0]  io_alu_command;
  logic [31:0] io_alu_a, io_alu_b, io_alu_out;
  logic        io_alu_zero;
  logic        io_resp_valid;
  logic        io_resp_ready = 1'b1;
  logic [31:0] io_resp_data;
  logic        io_resp_zero, io_resp_err, io_busy;
  logic [3:0]  io_dbg_addr = '0;
  logic [31:0] io_dbg_data;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  alu_issue_unit dut (
    .clock          (clock),
    .reset          (reset),
    .io_req_valid   (io_req_valid),
    .io_req_ready   (io_req_ready),
    .io_req_bits    (io_req_bits),
    .io_alu_command (io_alu_command),
    .io_alu_a       (io_alu_a),
    .io_alu_b       (io_alu_b),
    .io_alu_out     (io_alu_out),
    .io_alu_zero    (io_alu_zero),
    .io_resp_valid  (io_resp_valid),
    .io_resp_ready  (io_resp_ready),
    .io_resp_data   (io_resp_data),
    .io_resp_zero   (io_resp_zero),
    .io_resp_err    (io_resp_err),
    .io_busy        (io_busy),
    .io_dbg_addr    (io_dbg_addr),
    .io_dbg_data    (io_dbg_data)
  );

  // Combinational ALU; shifts use b[4:0]
  always_comb begin
    io_alu_out = '0;
    case (io_alu_command)
      8'd1: io_alu_out = io_alu_a + io_alu_b;
      8'd2: io_alu_out = io_alu_a - io_alu_b;
      8'd3: io_alu_out = io_alu_a & io_alu_b;
      8'd4: io_alu_out = io_alu_a | io_alu_b;
      8'd5: io_alu_out = io_alu_a ^ io_alu_b;
      8'd6: io_alu_out = io_alu_a >> io_alu_b[4:0];
      8'd7: io_alu_out = $signed(io_alu_a) >>> io_alu_b[4:0];
      8'd8: io_alu_out = io_alu_a << io_alu_b[4:0];
      default: io_alu_out = '0;
    endcase
  end
  assign io_alu_zero = (io_alu_out == 32'd0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!io_req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("req_ready_wait", {31'd0, io_req_ready}, 32'd1);
  endtask

  task automatic issue(input logic [31:0] instr);
    wait_ready();
    io_req_valid = 1'b1;
    io_req_bits  = instr;
    @(posedge clock);
    #1;
    io_req_valid = 1'b0;
    io_req_bits  = '0;
  endtask

  // Issues one instruction with resp_ready held high and checks every stage.
  task automatic run_op(input string tag, input logic [31:0] instr, input logic [7:0] ecmd,
                        input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] edata,
                        input logic ezero, input logic eerr, input logic [3:0] rd,
                        input logic [31:0] edbg);
    issue(instr);
    @(negedge clock);
    check({tag, ":read_cmd"}, {24'd0, io_alu_command}, 32'd0);
    check({tag, ":read_busy"}, {31'd0, io_busy}, 32'd1);
    if (!eerr) begin
      @(negedge clock);
      check({tag, ":exec_cmd"}, {24'd0, io_alu_command}, {24'd0, ecmd});
      check({tag, ":exec_a"}, io_alu_a, ea);
      check({tag, ":exec_b"}, io_alu_b, eb);
    end
    @(negedge clock);
    check({tag, ":resp_cmd"}, {24'd0, io_alu_command}, 32'd0);
    check({tag, ":resp_valid"}, {31'd0, io_resp_valid}, 32'd1);
    check({tag, ":resp_data"}, io_resp_data, edata);
    check({tag, ":resp_zero"}, {31'd0, io_resp_zero}, {31'd0, ezero});
    check({tag, ":resp_err"}, {31'd0, io_resp_err}, {31'd0, eerr});
    io_dbg_addr = rd;
    #1;
    check({tag, ":dbg"}, io_dbg_data, edbg);
    @(negedge clock);
    check({tag, ":post_valid"}, {31'd0, io_resp_valid}, 32'd0);
    check({tag, ":post_err"}, {31'd0, io_resp_err}, 32'd0);
    check({tag, ":post_ready"}, {31'd0, io_req_ready}, 32'd1);
  endtask

  initial begin
    // Reset held, then released
    repeat (3) @(negedge clock);
    check("rst_held_ready", {31'd0, io_req_ready}, 32'd0);
    check("rst_held_busy", {31'd0, io_busy}, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("rst_ready", {31'd0, io_req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, io_resp_valid}, 32'd0);
    check("rst_alu_cmd", {24'd0, io_alu_command}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      io_dbg_addr = 4'(i);
      #1;
      check($sformatf("rst_dbg_r%0d", i), io_dbg_data, 32'd0);
    end

    run_op("add_imm5",  32'h0110_0805, 8'd1, 32'd0, 32'd5, 32'd5, 1'b0, 1'b0, 4'd1, 32'd5);
    run_op("sub_zero",  32'h0221_1000, 8'd2, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 4'd2, 32'd0);
    run_op("add_neg",   32'h0130_0FFB, 8'd1, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 1'b0, 1'b0, 4'd3, 32'hFFFF_FFFB);
    run_op("sra",       32'h0743_0801, 8'd7, 32'hFFFF_FFFB, 32'd1, 32'hFFFF_FFFD, 1'b0, 1'b0, 4'd4, 32'hFFFF_FFFD);
    run_op("srl",       32'h0653_0801, 8'd6, 32'hFFFF_FFFB, 32'd1, 32'h7FFF_FFFD, 1'b0, 1'b0, 4'd5, 32'h7FFF_FFFD);
    run_op("or_rr",     32'h0463_1000, 8'd4, 32'hFFFF_FFFB, 32'd5, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'd6, 32'hFFFF_FFFF);
    run_op("sll",       32'h0871_0804, 8'd8, 32'd5, 32'd4, 32'h0000_0050, 1'b0, 1'b0, 4'd7, 32'h0000_0050);
    run_op("xor_self",  32'h0583_3000, 8'd5, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'd0, 1'b1, 1'b0, 4'd8, 32'd0);
    run_op("and_rr",    32'h0394_5000, 8'd3, 32'hFFFF_FFFD, 32'h7FFF_FFFD, 32'h7FFF_FFFD, 1'b0, 1'b0, 4'd9, 32'h7FFF_FFFD);
    run_op("sub_wrap",  32'h02A0_1000, 8'd2, 32'd0, 32'd5, 32'hFFFF_FFFB, 1'b0, 1'b0, 4'd10, 32'hFFFF_FFFB);
    run_op("err_cmd9",  32'h0910_0805, 8'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 4'd1, 32'd5);
    run_op("err_cmd0",  32'h0010_0805, 8'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 4'd1, 32'd5);
    run_op("add_rd0",   32'h0100_0807, 8'd1, 32'd0, 32'd7, 32'd7, 1'b0, 1'b0, 4'd0, 32'd0);

    // Response back-pressure
    io_resp_ready = 1'b0;
    issue(32'h01C0_0803);
    repeat (3) @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold%0d_valid", i), {31'd0, io_resp_valid}, 32'd1);
      check($sformatf("hold%0d_data", i), io_resp_data, 32'd3);
      check($sformatf("hold%0d_ready", i), {31'd0, io_req_ready}, 32'd0);
      check($sformatf("hold%0d_busy", i), {31'd0, io_busy}, 32'd1);
      @(negedge clock);
    end
    io_resp_ready = 1'b1;
    @(negedge clock);
    check("hold_release_valid", {31'd0, io_resp_valid}, 32'd0);
    check("hold_release_ready", {31'd0, io_req_ready}, 32'd1);

    // Reset asserted while in EXEC
    issue(32'h01B0_0809);
    @(negedge clock);
    @(negedge clock);
    check("abort_exec_cmd", {24'd0, io_alu_command}, 32'd1);
    reset = 1'b0;
    @(negedge clock);
    check("abort_cmd", {24'd0, io_alu_command}, 32'd0);
    check("abort_a", io_alu_a, 32'd0);
    check("abort_b", io_alu_b, 32'd0);
    check("abort_resp_valid", {31'd0, io_resp_valid}, 32'd0);
    check("abort_resp_data", io_resp_data, 32'd0);
    check("abort_busy", {31'd0, io_busy}, 32'd0);
    check("abort_ready_held", {31'd0, io_req_ready}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      io_dbg_addr = 4'(i);
      #1;
      check($sformatf("abort_dbg_r%0d", i), io_dbg_data, 32'd0);
    end
    reset = 1'b1;
    @(negedge clock);
    check("abort_ready_after", {31'd0, io_req_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
